// File: rtl/bin_to_dec_seq.sv
// Sequential 16-bit binary to BCD converter (double dabble, one bit per clock)
// with a per-digit leading-zero blank mask for a display driver.
module bin_to_dec_seq #(
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] number,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [7:0]  blank
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] BLANK_RST = (BLANK_LZ != 0) ? 8'hFE : 8'hE0;

    state_t      state_q, state_d;
    logic [15:0] sr_q, sr_d;
    logic [19:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic [7:0]  blank_q, blank_d;
    logic        done_q, done_d;
    logic [19:0] acc_adj;

    // Add 3 to every BCD nibble of 5 or more so the following shift carries correctly.
    function automatic logic [19:0] dabble_adjust(input logic [19:0] acc);
        logic [19:0] r;
        r = acc;
        for (int i = 0; i < 5; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Digit 0 is always lit; digits 5..7 never exist for a 16-bit operand.
    function automatic logic [7:0] blank_mask(input logic [19:0] acc);
        logic [7:0] m;
        m = 8'hE0;
        if (BLANK_LZ != 0) begin
            m[4] = (acc[19:16] == 4'd0);
            m[3] = (acc[19:12] == 12'd0);
            m[2] = (acc[19:8]  == 12'd0);
            m[1] = (acc[19:4]  == 16'd0);
        end
        return m;
    endfunction

    assign acc_adj = dabble_adjust(acc_q);

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        blank_d  = blank_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = number;
                    acc_d   = 20'd0;
                    cnt_d   = 4'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = {acc_adj[18:0], sr_q[15]};
                sr_d  = {sr_q[14:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d = {12'h000, acc_q};
                blank_d  = blank_mask(acc_q);
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            result_q <= 32'h0000_0000;
            blank_q  <= BLANK_RST;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            result_q <= result_d;
            blank_q  <= blank_d;
        end
    end

    // Working datapath registers carry no reset; IDLE reloads them on every accept.
    always_ff @(posedge clk) begin
        sr_q  <= sr_d;
        acc_q <= acc_d;
        cnt_q <= cnt_d;
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign blank  = blank_q;

endmodule
